// File: rtl/decode_issue.sv
// decode_issue -- decode-to-execute issue stage (ID/EX pipeline register).
//
// Selects the A/B operands. The zero register wins over forwarding, and
// forwarding wins over the register file. Detects load-use hazards against
// the instruction in execute and updates the ID/EX register with priority
// reset > flush > hold > bubble > load.
//
// Ports
//   clk, rst                   clock; synchronous active-low reset
//   instr_valid_d, pc_d, imm_d decode instruction presence, PC, immediate
//   rs_d, rt_d, rd_d           decode register specifiers
//   use_rs_d, use_rt_d         instruction really reads rs / rt
//   ctrl_d[15:0]               bit0 reg_write, bit1 mem_to_reg, rest passed through
//   rf_rd1, rf_rd2             register-file read data
//   forward_src_{a,b}[_enabled] forwarding-unit data / select
//   write_reg_e                destination register of the execute instruction
//   branch_taken_e             squash the decode instruction
//   ex_ready                   execute accepts a new instruction
//   stall_d                    hold fetch/decode this cycle
//   valid_e .. ctrl_e          ID/EX register contents
//   stall_cnt                  load-use bubble count
//
// Build option: define DECODE_ISSUE_STATS_EN to enable the stall_cnt
// counter. When it is not defined, stall_cnt is tied to 0.
module decode_issue (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid_d,
  input  logic [31:0] pc_d,
  input  logic [31:0] imm_d,
  input  logic [4:0]  rs_d,
  input  logic [4:0]  rt_d,
  input  logic [4:0]  rd_d,
  input  logic        use_rs_d,
  input  logic        use_rt_d,
  input  logic [15:0] ctrl_d,
  input  logic [31:0] rf_rd1,
  input  logic [31:0] rf_rd2,
  input  logic        forward_src_a_enabled,
  input  logic        forward_src_b_enabled,
  input  logic [31:0] forward_src_a,
  input  logic [31:0] forward_src_b,
  input  logic [4:0]  write_reg_e,
  input  logic        branch_taken_e,
  input  logic        ex_ready,
  output logic        stall_d,
  output logic        valid_e,
  output logic [31:0] pc_e,
  output logic [31:0] src_a_e,
  output logic [31:0] src_b_e,
  output logic [31:0] imm_e,
  output logic [4:0]  rs_e,
  output logic [4:0]  rt_e,
  output logic [4:0]  rd_e,
  output logic [15:0] ctrl_e,
  output logic [31:0] stall_cnt
);

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] ctrl;
  } idex_t;

  idex_t       idex_q, idex_d;
  logic [31:0] opa, opb;
  logic        lu, hold, bubble;

  // r0 reads as zero even when a forwarding path claims it.
  always_comb begin
    opa = rf_rd1;
    if (rs_d == 5'd0)               opa = '0;
    else if (forward_src_a_enabled) opa = forward_src_a;
    opb = rf_rd2;
    if (rt_d == 5'd0)               opb = '0;
    else if (forward_src_b_enabled) opb = forward_src_b;
  end

  // Load in execute (mem_to_reg) whose destination this instruction reads.
  assign lu = instr_valid_d & idex_q.valid & idex_q.ctrl[1] &
              (write_reg_e != 5'd0) &
              ((use_rs_d & (rs_d == write_reg_e)) |
               (use_rt_d & (rt_d == write_reg_e)));

  assign hold    = idex_q.valid & ~ex_ready;
  // A bubble is only inserted when neither a flush nor a hold is active.
  // The stats counter counts exactly these edges.
  assign bubble  = lu & ~branch_taken_e & ~hold;
  assign stall_d = ~branch_taken_e & (lu | hold);

  always_comb begin
    idex_d = idex_q;
    if (branch_taken_e) begin
      idex_d = '0;
    end else if (hold) begin
      idex_d = idex_q;
    end else if (lu) begin
      idex_d = '0;
    end else begin
      idex_d.valid = instr_valid_d;
      idex_d.pc    = pc_d;
      idex_d.src_a = opa;
      idex_d.src_b = opb;
      idex_d.imm   = imm_d;
      idex_d.rs    = rs_d;
      idex_d.rt    = rt_d;
      idex_d.rd    = rd_d;
      idex_d.ctrl  = ctrl_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) idex_q <= '0;
    else      idex_q <= idex_d;
  end

`ifdef DECODE_ISSUE_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Wraps from all-ones to zero naturally.
  assign stall_cnt_d = bubble ? stall_cnt_q + 32'd1 : stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) stall_cnt_q <= '0;
    else      stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

  assign valid_e = idex_q.valid;
  assign pc_e    = idex_q.pc;
  assign src_a_e = idex_q.src_a;
  assign src_b_e = idex_q.src_b;
  assign imm_e   = idex_q.imm;
  assign rs_e    = idex_q.rs;
  assign rt_e    = idex_q.rt;
  assign rd_e    = idex_q.rd;
  assign ctrl_e  = idex_q.ctrl;

endmodule

// File: tb/tb_decode_issue.sv
module tb_decode_issue;

`ifdef DECODE_ISSUE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid_d;
  logic [31:0] pc_d, imm_d;
  logic [4:0]  rs_d, rt_d, rd_d;
  logic        use_rs_d, use_rt_d;
  logic [15:0] ctrl_d;
  logic [31:0] rf_rd1, rf_rd2;
  logic        forward_src_a_enabled, forward_src_b_enabled;
  logic [31:0] forward_src_a, forward_src_b;
  logic [4:0]  write_reg_e;
  logic        branch_taken_e, ex_ready;
  logic        stall_d, valid_e;
  logic [31:0] pc_e, src_a_e, src_b_e, imm_e, stall_cnt;
  logic [4:0]  rs_e, rt_e, rd_e;
  logic [15:0] ctrl_e;

  decode_issue dut (
    .clk(clk), .rst(rst), .instr_valid_d(instr_valid_d), .pc_d(pc_d), .imm_d(imm_d),
    .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d), .use_rs_d(use_rs_d), .use_rt_d(use_rt_d),
    .ctrl_d(ctrl_d), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .forward_src_a_enabled(forward_src_a_enabled), .forward_src_b_enabled(forward_src_b_enabled),
    .forward_src_a(forward_src_a), .forward_src_b(forward_src_b), .write_reg_e(write_reg_e),
    .branch_taken_e(branch_taken_e), .ex_ready(ex_ready), .stall_d(stall_d), .valid_e(valid_e),
    .pc_e(pc_e), .src_a_e(src_a_e), .src_b_e(src_b_e), .imm_e(imm_e), .rs_e(rs_e), .rt_e(rt_e),
    .rd_e(rd_e), .ctrl_e(ctrl_e), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] pc;
    logic [4:0]  rs, rt;
    logic        urs, urt;
    logic [15:0] ctrl;
    logic [31:0] rf1, rf2;
    logic        fae;
    logic [31:0] fa;
    logic        fbe;
    logic [31:0] fb;
    logic [4:0]  wre;
    logic        br, exr;
    logic        x_stall, x_valid;
    logic [31:0] x_a, x_b, x_pc;
    logic [15:0] x_ctrl;
  } vec_t;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    instr_valid_d = v.iv;      pc_d = v.pc;        imm_d = ~v.pc;
    rs_d = v.rs;               rt_d = v.rt;        rd_d = 5'd17;
    use_rs_d = v.urs;          use_rt_d = v.urt;   ctrl_d = v.ctrl;
    rf_rd1 = v.rf1;            rf_rd2 = v.rf2;
    forward_src_a_enabled = v.fae; forward_src_a = v.fa;
    forward_src_b_enabled = v.fbe; forward_src_b = v.fb;
    write_reg_e = v.wre;       branch_taken_e = v.br; ex_ready = v.exr;
  endtask

  // Advance one clock edge and sample 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl [11];
  vec_t v;

  initial begin
    // inputs                                                                                           expected
    //        iv    pc         rs    rt    urs   urt   ctrl      rf1        rf2       fae   fa         fbe   fb         wre   br    exr     stall valid a          b          pc         ctrl
    tbl[0]  = '{1'b1, 32'h100, 5'd5, 5'd6, 1'b1, 1'b1, 16'h0001, 32'hDEAD,  32'h55,   1'b1, 32'h1234,  1'b0, 32'h0,     5'd0, 1'b0, 1'b1,   1'b0, 1'b1, 32'h1234,  32'h55,    32'h100, 16'h0001};
    tbl[1]  = '{1'b1, 32'h104, 5'd0, 5'd0, 1'b1, 1'b1, 16'h8004, 32'hDEAD,  32'h77,   1'b1, 32'hFFFF,  1'b0, 32'h0,     5'd0, 1'b0, 1'b1,   1'b0, 1'b1, 32'h0,     32'h0,     32'h104, 16'h8004};
    tbl[2]  = '{1'b1, 32'h108, 5'd7, 5'd8, 1'b1, 1'b1, 16'h0003, 32'hA5A5,  32'h1111, 1'b0, 32'h0,     1'b1, 32'hBEEF,  5'd0, 1'b0, 1'b1,   1'b0, 1'b1, 32'hA5A5,  32'hBEEF,  32'h108, 16'h0003};
    tbl[3]  = '{1'b1, 32'h10C, 5'd3, 5'd0, 1'b1, 1'b0, 16'h0001, 32'h33,    32'h0,    1'b0, 32'h0,     1'b0, 32'h0,     5'd3, 1'b0, 1'b1,   1'b1, 1'b0, 32'h0,     32'h0,     32'h0,   16'h0000};
    tbl[4]  = '{1'b1, 32'h10C, 5'd3, 5'd0, 1'b1, 1'b0, 16'h0001, 32'h33,    32'h0,    1'b1, 32'h4444,  1'b0, 32'h0,     5'd3, 1'b0, 1'b1,   1'b0, 1'b1, 32'h4444,  32'h0,     32'h10C, 16'h0001};
    tbl[5]  = '{1'b0, 32'h200, 5'd9, 5'd0, 1'b1, 1'b0, 16'h0010, 32'h99,    32'h0,    1'b0, 32'h0,     1'b0, 32'h0,     5'd0, 1'b0, 1'b1,   1'b0, 1'b0, 32'h99,    32'h0,     32'h200, 16'h0010};
    tbl[6]  = '{1'b1, 32'h300, 5'd1, 5'd2, 1'b1, 1'b1, 16'h0002, 32'h11,    32'h22,   1'b0, 32'h0,     1'b0, 32'h0,     5'd0, 1'b0, 1'b0,   1'b0, 1'b1, 32'h11,    32'h22,    32'h300, 16'h0002};
    tbl[7]  = '{1'b1, 32'h304, 5'd4, 5'd0, 1'b1, 1'b1, 16'h0006, 32'h40,    32'h77,   1'b0, 32'h0,     1'b0, 32'h0,     5'd0, 1'b0, 1'b1,   1'b0, 1'b1, 32'h40,    32'h0,     32'h304, 16'h0006};
    tbl[8]  = '{1'b1, 32'h308, 5'd5, 5'd5, 1'b0, 1'b0, 16'h0002, 32'h50,    32'h55,   1'b0, 32'h0,     1'b0, 32'h0,     5'd5, 1'b0, 1'b1,   1'b0, 1'b1, 32'h50,    32'h55,    32'h308, 16'h0002};
    tbl[9]  = '{1'b1, 32'h30C, 5'd1, 5'd5, 1'b0, 1'b1, 16'h0001, 32'h11,    32'h55,   1'b0, 32'h0,     1'b0, 32'h0,     5'd5, 1'b0, 1'b1,   1'b1, 1'b0, 32'h0,     32'h0,     32'h0,   16'h0000};
    tbl[10] = '{1'b1, 32'h400, 5'd2, 5'd0, 1'b1, 1'b0, 16'h0001, 32'h22,    32'h0,    1'b0, 32'h0,     1'b0, 32'h0,     5'd0, 1'b1, 1'b0,   1'b0, 1'b0, 32'h0,     32'h0,     32'h0,   16'h0000};

    // Reset, with a valid instruction present that must not be captured.
    rst = 1'b0;
    drive(tbl[0]);
    step(); step();
    chk("rst_valid_e", 32'(valid_e), 32'h0);
    chk("rst_src_a_e", src_a_e, 32'h0);
    chk("rst_pc_e", pc_e, 32'h0);
    chk("rst_ctrl_e", 32'(ctrl_e), 32'h0);
    chk("rst_stall_cnt", stall_cnt, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("rst_stall_d", 32'(stall_d), 32'h0);

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1 chk($sformatf("v%0d_stall_d", i), 32'(stall_d), 32'(tbl[i].x_stall));
      step();
      chk($sformatf("v%0d_valid_e", i), 32'(valid_e), 32'(tbl[i].x_valid));
      chk($sformatf("v%0d_src_a_e", i), src_a_e, tbl[i].x_a);
      chk($sformatf("v%0d_src_b_e", i), src_b_e, tbl[i].x_b);
      chk($sformatf("v%0d_pc_e", i), pc_e, tbl[i].x_pc);
      chk($sformatf("v%0d_ctrl_e", i), 32'(ctrl_e), 32'(tbl[i].x_ctrl));
    end
    // Two bubbles were inserted (vectors 3 and 9).
    chk("tbl_stall_cnt", stall_cnt, STATS ? 32'd2 : 32'd0);

    // Multi-cycle hold, with a load-use hazard present at the same time.
    @(negedge clk);
    v = tbl[0];
    v.pc = 32'h500; v.rs = 5'd3; v.rt = 5'd4; v.fae = 1'b0; v.rf1 = 32'h5A;
    v.rf2 = 32'h6B; v.ctrl = 16'h0007; v.wre = 5'd0; v.exr = 1'b1;
    drive(v);
    step();
    chk("ld_valid_e", 32'(valid_e), 32'h1);
    chk("ld_imm_e", imm_e, ~32'h500);
    chk("ld_rd_e", 32'(rd_e), 32'd17);
    chk("ld_rs_e", 32'(rs_e), 32'd3);
    chk("ld_rt_e", 32'(rt_e), 32'd4);
    @(negedge clk);
    v.pc = 32'h600; v.rf1 = 32'h77; v.ctrl = 16'h0001; v.wre = 5'd3; v.exr = 1'b0;
    drive(v);
    for (int c = 0; c < 3; c++) begin
      #1 chk($sformatf("hold%0d_stall_d", c), 32'(stall_d), 32'h1);
      step();
      chk($sformatf("hold%0d_valid_e", c), 32'(valid_e), 32'h1);
      chk($sformatf("hold%0d_pc_e", c), pc_e, 32'h500);
      chk($sformatf("hold%0d_src_a_e", c), src_a_e, 32'h5A);
      chk($sformatf("hold%0d_ctrl_e", c), 32'(ctrl_e), 32'h7);
      chk($sformatf("hold%0d_stall_cnt", c), stall_cnt, STATS ? 32'd2 : 32'd0);
      @(negedge clk);
    end

    // Flush during hold.
    v.br = 1'b1;
    drive(v);
    #1 chk("flush_stall_d", 32'(stall_d), 32'h0);
    step();
    chk("flush_valid_e", 32'(valid_e), 32'h0);
    chk("flush_ctrl_e", 32'(ctrl_e), 32'h0);
    chk("flush_imm_e", imm_e, 32'h0);
    chk("flush_rd_e", 32'(rd_e), 32'h0);
    chk("flush_stall_cnt", stall_cnt, STATS ? 32'd2 : 32'd0);

    // Reset during a load-use stall.
    @(negedge clk);
    v = tbl[0];
    v.pc = 32'h700; v.rs = 5'd1; v.urs = 1'b0; v.urt = 1'b0; v.ctrl = 16'h0003;
    v.fae = 1'b0; v.rf1 = 32'h71;
    drive(v);
    step();
    @(negedge clk);
    v.pc = 32'h704; v.rs = 5'd3; v.urs = 1'b1; v.ctrl = 16'h0001; v.wre = 5'd3; v.rf1 = 32'h73;
    drive(v);
    #1 chk("rstlu_stall_d", 32'(stall_d), 32'h1);
    rst = 1'b0;
    step();
    chk("rstlu_valid_e", 32'(valid_e), 32'h0);
    chk("rstlu_pc_e", pc_e, 32'h0);
    chk("rstlu_stall_cnt", stall_cnt, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("rstlu_after_stall_d", 32'(stall_d), 32'h0);
    step();
    chk("rstlu_issue_valid_e", 32'(valid_e), 32'h1);
    chk("rstlu_issue_src_a_e", src_a_e, 32'h73);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
